// File: rtl/ext_bus_sequencer_pkg.sv
// ext_bus_sequencer_pkg: shared bus-cycle states, grant ids and pin output-enable patterns
package ext_bus_sequencer_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR_LO = 2'd1,
        ADDR_HI = 2'd2,
        DATA    = 2'd3
    } state_t;
    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;
    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } xfer_t;
    localparam logic [7:0] OE_NONE    = 8'h00;
    localparam logic [7:0] OE_RW_ONLY = 8'h01;
    localparam logic [7:0] OE_ALL     = 8'hFF;
    localparam logic [3:0] WAIT_MAX   = 4'd15;
    function automatic logic rw_pin(input logic we, input logic rw_read);
        return we ? ~rw_read : rw_read;
    endfunction
endpackage

// File: rtl/bus_arbiter2.sv
// bus_arbiter2: two-way grant (round-robin or data-first) with the last_grant register
module bus_arbiter2
    import ext_bus_sequencer_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic   clk_cpu,
    input  logic   rst_n,
    input  logic   fetch_req,
    input  logic   data_req,
    input  logic   take,
    output logic   valid,
    output grant_t grant
);
    grant_t last_grant;
    grant_t tie_grant;
    assign valid = fetch_req || data_req;
    assign tie_grant = (FIXED_PRIO != 0 || last_grant == GRANT_FETCH) ? GRANT_DATA : GRANT_FETCH;
    assign grant = (fetch_req && data_req) ? tie_grant : data_req ? GRANT_DATA : GRANT_FETCH;
    always_ff @(posedge clk_cpu) begin
        if (!rst_n)
            last_grant <= GRANT_FETCH;
        else if (take && valid)
            last_grant <= grant;
    end
endmodule

// File: rtl/ext_bus_sequencer.sv
// ext_bus_sequencer: arbitrated 3-phase external bus cycles; EXT_BUS_WAIT_STATE_EN adds mem_ready wait states
module ext_bus_sequencer
    import ext_bus_sequencer_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter bit RW_READ    = 1'b1
) (
    input  logic        clk_cpu,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic        fetch_ack,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [15:0] data_addr,
    input  logic [7:0]  data_wdata,
    output logic        data_ack,
    output logic [7:0]  rdata,
    output logic        busy,
`ifdef EXT_BUS_WAIT_STATE_EN
    input  logic        mem_ready,
`endif
    output logic [7:0]  uo_out,
    input  logic [7:0]  uio_in,
    output logic [7:0]  uio_out,
    output logic [7:0]  uio_oe
);
    state_t state, state_nx;
    grant_t cur_grant, grant;
    xfer_t  cur;
    logic   arb_valid, decide, done, forced, fetch_live, data_live, addr_phase, wr_phase;
    // the requester being acked on this edge still shows its old req; it must not be re-granted
    assign fetch_live = fetch_req && !(state == DATA && cur_grant == GRANT_FETCH);
    assign data_live  = data_req && !(state == DATA && cur_grant == GRANT_DATA);
`ifdef EXT_BUS_WAIT_STATE_EN
    logic [3:0] wait_cnt;
    assign done   = state == DATA && (mem_ready || wait_cnt == WAIT_MAX);
    assign forced = state == DATA && !mem_ready && wait_cnt == WAIT_MAX;
    always_ff @(posedge clk_cpu) begin
        if (!rst_n || state != DATA || done)
            wait_cnt <= 4'd0;
        else
            wait_cnt <= wait_cnt + 4'd1;
    end
`else
    assign done   = state == DATA;
    assign forced = 1'b0;
`endif
    assign decide = state == IDLE || done;
    bus_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .clk_cpu (clk_cpu),
        .rst_n   (rst_n),
        .fetch_req(fetch_live),
        .data_req(data_live),
        .take    (decide),
        .valid   (arb_valid),
        .grant   (grant)
    );
    always_comb begin
        state_nx = state;
        if (decide)
            state_nx = arb_valid ? ADDR_LO : IDLE;
        else if (state == ADDR_LO)
            state_nx = ADDR_HI;
        else if (state == ADDR_HI)
            state_nx = DATA;
    end
    always_ff @(posedge clk_cpu) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= '0;
            cur_grant <= GRANT_FETCH;
            fetch_ack <= 1'b0;
            data_ack  <= 1'b0;
            rdata     <= 8'h00;
        end else begin
            state     <= state_nx;
            fetch_ack <= done && cur_grant == GRANT_FETCH;
            data_ack  <= done && cur_grant == GRANT_DATA;
            if (done && !cur.we)
                rdata <= forced ? 8'hFF : uio_in;
            if (decide && arb_valid) begin
                cur_grant <= grant;
                cur.addr  <= grant == GRANT_DATA ? data_addr : fetch_addr;
                cur.we    <= grant == GRANT_DATA && data_we;
                cur.wdata <= data_wdata;
            end
        end
    end
    // pins come only from state and latched transfer fields
    assign addr_phase = state == ADDR_LO || state == ADDR_HI;
    assign wr_phase   = state == DATA && cur.we;
    assign busy    = state != IDLE;
    assign uo_out  = state == IDLE ? 8'h00 : state == ADDR_LO ? cur.addr[7:0] : cur.addr[15:8];
    assign uio_out = addr_phase ? {7'b0, rw_pin(cur.we, RW_READ)} : wr_phase ? cur.wdata : 8'h00;
    assign uio_oe  = addr_phase ? OE_RW_ONLY : wr_phase ? OE_ALL : OE_NONE;
endmodule
